// File: rtl/visited_bitmap.sv
// Visited-vertex bitmap: pipelined atomic test-and-set with in-flight write
// forwarding, a distinct-vertex counter and a word-at-a-time clear sweep.
module visited_bitmap #(
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           v_addr_in,
  input  logic                  v_addr_valid_in,
  input  logic                  clear_in,
  output logic                  ready_out,
  output logic                  visited_out,
  output logic                  valid_v_out,
  output logic                  range_err_out,
  output logic [DEPTH_BITS:0]   visited_count_out
);
  localparam int WA = DEPTH_BITS - 5;
  localparam int WORDS = 1 << WA;
  localparam logic [WA-1:0] LAST_WORD = {WA{1'b1}};
  localparam logic [DEPTH_BITS:0] COUNT_MAX = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] COUNT_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic               ready_r, ready_next_s;
  logic [WA-1:0]      clr_idx_r;
  logic [31:0]        mem_r [WORDS];
  logic [31:0]        rd_word_r;
  logic               acc_s, in_range_s;
  logic [WA-1:0]      req_word_s;
  logic [4:0]         req_bit_s;
  logic               s1_valid_r, s1_oor_r;
  logic [WA-1:0]      s1_word_r;
  logic [4:0]         s1_bit_r;
  logic [31:0]        base_word_s, new_word_s;
  logic               old_bit_s;
  logic               s2_valid_r, s2_oor_r, s2_old_r;
  logic [WA-1:0]      s2_word_r;
  logic [31:0]        s2_data_r;
  logic               wb_valid_r;
  logic [WA-1:0]      wb_word_r;
  logic [31:0]        wb_data_r;
  logic               mem_wen_s;
  logic [WA-1:0]      mem_waddr_s;
  logic [31:0]        mem_wdata_s;
  logic               valid_r, visited_r, range_err_r;
  logic [DEPTH_BITS:0] count_r;

  assign acc_s      = v_addr_valid_in & ready_r;
  assign in_range_s = (v_addr_in >> DEPTH_BITS) == 32'd0;
  assign req_word_s = v_addr_in[DEPTH_BITS-1:5];
  assign req_bit_s  = v_addr_in[4:0];

  // Stage 1 request register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_r <= 1'b0;
      s1_oor_r   <= 1'b0;
      s1_word_r  <= {WA{1'b0}};
      s1_bit_r   <= 5'd0;
    end else begin
      s1_valid_r <= acc_s;
      if (acc_s) begin
        s1_oor_r  <= ~in_range_s;
        s1_word_r <= req_word_s;
        s1_bit_r  <= req_bit_s;
      end
    end
  end

  // Registered bitmap read (BRAM-style, old data on a same-edge write)
  always_ff @(posedge clk_in) begin
    rd_word_r <= mem_r[req_word_s];
  end

  // Bitmap write port
  always_ff @(posedge clk_in) begin
    if (mem_wen_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Newest pending copy of the word wins: stage 2, then the word written last edge
  always_comb begin
    base_word_s = rd_word_r;
    if (s2_valid_r && !s2_oor_r && (s2_word_r == s1_word_r)) begin
      base_word_s = s2_data_r;
    end else if (wb_valid_r && (wb_word_r == s1_word_r)) begin
      base_word_s = wb_data_r;
    end else begin
      base_word_s = rd_word_r;
    end
    old_bit_s  = base_word_s[s1_bit_r];
    new_word_s = base_word_s | (32'd1 << s1_bit_r);
  end

  // Stage 2 and last-write registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s2_valid_r <= 1'b0;
      s2_oor_r   <= 1'b0;
      s2_old_r   <= 1'b0;
      s2_word_r  <= {WA{1'b0}};
      s2_data_r  <= 32'd0;
      wb_valid_r <= 1'b0;
      wb_word_r  <= {WA{1'b0}};
      wb_data_r  <= 32'd0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_oor_r   <= s1_oor_r;
      s2_old_r   <= s1_oor_r | old_bit_s;
      s2_word_r  <= s1_word_r;
      s2_data_r  <= new_word_s;
      wb_valid_r <= s2_valid_r & ~s2_oor_r;
      wb_word_r  <= s2_word_r;
      wb_data_r  <= s2_data_r;
    end
  end

  // Write-port arbitration: the sweep only runs with the pipeline empty
  always_comb begin
    mem_wen_s   = 1'b0;
    mem_waddr_s = clr_idx_r;
    mem_wdata_s = 32'd0;
    if (rst_in) begin
      mem_wen_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_wen_s   = 1'b1;
      mem_waddr_s = clr_idx_r;
      mem_wdata_s = 32'd0;
    end else if (s2_valid_r && !s2_oor_r) begin
      mem_wen_s   = 1'b1;
      mem_waddr_s = s2_word_r;
      mem_wdata_s = s2_data_r;
    end else begin
      mem_wen_s = 1'b0;
    end
  end

  // FSM state register and sweep counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= CLEAR;
      clr_idx_r <= {WA{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == CLEAR) && (clr_idx_r != LAST_WORD)) begin
        clr_idx_r <= clr_idx_r + {{(WA-1){1'b0}}, 1'b1};
      end else begin
        clr_idx_r <= {WA{1'b0}};
      end
    end
  end

  // FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = clear_in ? DRAIN : IDLE;
      DRAIN:   state_next_s = (!s1_valid_r && !s2_valid_r) ? CLEAR : DRAIN;
      CLEAR:   state_next_s = (clr_idx_r == LAST_WORD) ? IDLE : CLEAR;
      default: state_next_s = CLEAR;
    endcase
  end

  // FSM outputs (registered below, so decoded from the next state)
  always_comb begin
    ready_next_s = 1'b0;
    if (state_next_s == IDLE) begin
      ready_next_s = 1'b1;
    end else begin
      ready_next_s = 1'b0;
    end
  end

  // Registered response, ready and count
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_r     <= 1'b0;
      valid_r     <= 1'b0;
      visited_r   <= 1'b0;
      range_err_r <= 1'b0;
      count_r     <= {(DEPTH_BITS+1){1'b0}};
    end else begin
      ready_r     <= ready_next_s;
      valid_r     <= s2_valid_r;
      visited_r   <= s2_valid_r & s2_old_r;
      range_err_r <= s2_valid_r & s2_oor_r;
      if ((state_r != CLEAR) && (state_next_s == CLEAR)) begin
        count_r <= {(DEPTH_BITS+1){1'b0}};
      end else if (s2_valid_r && !s2_oor_r && !s2_old_r && (count_r != COUNT_MAX)) begin
        count_r <= count_r + COUNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign ready_out         = ready_r;
  assign valid_v_out       = valid_r;
  assign visited_out       = visited_r;
  assign range_err_out     = range_err_r;
  assign visited_count_out = count_r;
endmodule

// File: doc/visited_bitmap.md
VISITED_BITMAP -- requirements
Module: visited_bitmap

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 10, log2 of the number of tracked vertices (1024 vertices, 32 bitmap words of 32 bits).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port v_addr_in, input, 32 bits: vertex id for test-and-set.
REQ-005 SHALL have port v_addr_valid_in, input, 1 bit: request strobe; the request is accepted when high while ready_out is high.
REQ-006 SHALL have port clear_in, input, 1 bit: single-cycle pulse requesting a full bitmap clear.
REQ-007 SHALL have port ready_out, output, 1 bit: the block can accept requests.
REQ-008 SHALL have port visited_out, output, 1 bit: the previous visited state of the requested vertex.
REQ-009 SHALL have port valid_v_out, output, 1 bit: one-cycle strobe qualifying visited_out.
REQ-010 SHALL have port range_err_out, output, 1 bit: high together with valid_v_out when the vertex id is out of range.
REQ-011 SHALL have port visited_count_out, output, DEPTH_BITS+1 bits: number of distinct vertices currently set.

Function
REQ-012 SHALL perform an atomic test-and-set on each accepted request: return the old bit, then set the bit to 1.
REQ-013 SHALL assert valid_v_out exactly 2 cycles after acceptance (accept at edge N, strobe visible after edge N+2), with one response per accepted request, in order.
REQ-014 SHALL sustain a throughput of one request per cycle while ready_out is high.
REQ-015 SHALL store the bitmap as 2^(DEPTH_BITS-5) words of 32 bits, with a 1-cycle registered read (BRAM-style) in stage 1 and the word write-back in stage 2.
REQ-016 SHALL forward in-flight writes to later requests. A request to a vertex matching any older accepted, not-yet-written request (back-to-back, or one cycle apart) SHALL return visited_out=1. A read-during-write hazard on the same word SHALL merge the pending bit.
REQ-017 SHALL treat v_addr_in >= 2^DEPTH_BITS as an out-of-range request: visited_out=1, range_err_out=1, no bitmap write, count unchanged, latency unchanged.
REQ-018 SHALL increment visited_count_out by 1 in the response cycle only when the old bit is 0 and the address is in range. The count SHALL saturate at 2^DEPTH_BITS.
REQ-019 SHALL use a state machine with states IDLE, DRAIN and CLEAR.
 - IDLE: ready_out=1.
 - clear_in in IDLE goes to DRAIN; ready_out=0 from the next cycle.
 - DRAIN waits until both pipeline stages are empty, with in-flight responses delivered normally, then goes to CLEAR.
 - CLEAR writes 0 to one word per cycle, word 0 upward, for 2^(DEPTH_BITS-5) cycles; it zeroes visited_count_out on entry and returns to IDLE after the last word.
REQ-020 SHALL ignore v_addr_valid_in while ready_out=0: no response and no state change.
REQ-021 SHALL take clear_in and v_addr_valid_in in the same IDLE cycle as follows: the request is accepted and answered, then the clear proceeds via DRAIN.
REQ-022 SHALL ignore clear_in while in DRAIN or CLEAR, with no queued second clear.
REQ-023 SHALL keep the word-address counter wrap-free: CLEAR terminates on the last word index.

Reset
REQ-024 SHALL, while rst_in is high, drive valid_v_out=0, visited_out=0, range_err_out=0, ready_out=0 and visited_count_out=0.
REQ-025 SHALL, while rst_in is high, discard in-flight requests and force state CLEAR with the word counter at 0.
REQ-026 SHALL, after rst_in deasserts, complete the clear sweep (32 cycles at default) before ready_out rises. Reset asserted mid-operation SHALL behave identically.

Verification
REQ-027 SHALL cover post-reset init: rst_in 1 cycle -> ready_out low 32 cycles then high; visited_count_out=0.
REQ-028 SHALL cover basic test-and-set: request 1, then 55, then 1 on separate idle cycles -> responses 0, 0, 1 each 2 cycles after accept; visited_count_out=2.
REQ-029 SHALL cover the hazard case: back-to-back requests 64, 64, 65, 64 on consecutive cycles -> responses 0, 1, 0, 1 on consecutive cycles; count=2.
REQ-030 SHALL cover out-of-range input: request 1024 (DEPTH_BITS=10) -> visited_out=1, range_err_out=1; a subsequent request 0 -> visited_out=0; count unaffected by 1024.
REQ-031 SHALL cover clear with traffic: requests 3, 4 then clear_in on the next cycle -> both responses delivered (0, 0), ready_out low for DRAIN plus 32 cycles, count=0; request 3 afterwards -> 0.
REQ-032 SHALL cover reset mid-pipeline: rst_in on the cycle after accepting 7 -> no valid_v_out for 7; after the sweep, request 7 -> 0.
